token_decoder: RTL and testbench

Detokenizer for the tensor_core text path, the inverse of the encoder. It reads a zero-terminated stream of token codes from a code SRAM and resolves each code to its string in the vocab SRAM. It writes the concatenated characters plus a final 0x00 into an output SRAM. All three memories are external synchronous-read SRAM instances; this block only drives their address, data and write-enable ports.

---
 rtl/token_decoder_pkg.sv | 20 ++
 rtl/token_decoder_if.sv | 26 ++
 rtl/token_decoder_index.sv | 28 ++
 rtl/token_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_token_decoder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/token_decoder_pkg.sv
// Shared state encodings and constants for the token decoder.
package token_decoder_pkg;

  typedef logic [3:0] state_t;

  localparam state_t StIdle  = 4'd0;
  localparam state_t StBuild = 4'd1;
  localparam state_t StCRd   = 4'd2;
  localparam state_t StCChk  = 4'd3;
  localparam state_t StSRd   = 4'd4;
  localparam state_t StSChk  = 4'd5;
  localparam state_t StVRd   = 4'd6;
  localparam state_t StVChk  = 4'd7;
  localparam state_t StTerm  = 4'd8;
  localparam state_t StDone  = 4'd9;
  localparam state_t StErr   = 4'd10;

  localparam logic [7:0] TERM_CHAR = 8'h00;

endpackage

// File: rtl/token_decoder_if.sv
// Decoder-side bundle: start/status plus the code, vocab and output SRAM ports.
interface token_decoder_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  cs;
  logic [ADDR_WIDTH-1:0] code_addr;
  logic [DATA_WIDTH-1:0] code_rdata;
  logic [ADDR_WIDTH-1:0] vocab_addr;
  logic [DATA_WIDTH-1:0] vocab_rdata;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_wdata;
  logic                  out_we;
  logic                  done;
  logic                  err;

  modport master (
    input  cs, code_rdata, vocab_rdata,
    output code_addr, vocab_addr, out_addr, out_wdata, out_we, done, err
  );

  modport slave (
    output cs, code_rdata, vocab_rdata,
    input  code_addr, vocab_addr, out_addr, out_wdata, out_we, done, err
  );
endinterface

// File: rtl/token_decoder_index.sv
// Entry-start register file: written once per entry while the vocab is scanned,
// read asynchronously by token code.
module token_decoder_index #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [ADDR_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH-1:0] rdata
);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] entry_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) entry_q[i] <= '0;
    end else if (we) begin
      entry_q[waddr] <= wdata;
    end
  end

  assign rdata = entry_q[raddr];

endmodule

// File: rtl/token_decoder.sv
// Detokenizer: resolves a zero-terminated code stream through the vocab SRAM into the
// output SRAM. Define TOKEN_DECODER_INDEX_EN to pre-index entry starts instead of scanning.
module token_decoder
  import token_decoder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  token_decoder_if.master bus
);
  localparam logic [ADDR_WIDTH-1:0] AddrMax  = '1;
  localparam logic [ADDR_WIDTH-1:0] OneA     = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] TermChar = DATA_WIDTH'(TERM_CHAR);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ac_q, ac_d;
  logic [ADDR_WIDTH-1:0] va_q, va_d;
  logic [ADDR_WIDTH-1:0] oa_q, oa_d;
  // Next vocab byte read is the first byte of an entry; a 0x00 there ends the vocab.
  logic                  at_start_q, at_start_d;
  logic                  done_q, err_q;
  logic                  we;

`ifdef TOKEN_DECODER_INDEX_EN
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic                  idx_we;
  logic [ADDR_WIDTH-1:0] idx_rdata;

  token_decoder_index #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_index (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (idx_we),
    .waddr(cnt_q + OneA),
    .wdata(va_q),
    .raddr(ADDR_WIDTH'(bus.code_rdata)),
    .rdata(idx_rdata)
  );
`else
  localparam logic [DATA_WIDTH-1:0] OneD = DATA_WIDTH'(1);
  logic [DATA_WIDTH-1:0] skip_q, skip_d;
`endif

  always_comb begin
    state_d    = state_q;
    ac_d       = ac_q;
    va_d       = va_q;
    oa_d       = oa_q;
    at_start_d = at_start_q;
    we         = 1'b0;
`ifdef TOKEN_DECODER_INDEX_EN
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    idx_we     = 1'b0;
`else
    skip_d     = skip_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.cs) begin
          ac_d       = '0;
          va_d       = '0;
          oa_d       = '0;
          at_start_d = 1'b1;
`ifdef TOKEN_DECODER_INDEX_EN
          cnt_d      = '0;
          phase_d    = 1'b0;
          state_d    = StBuild;
`else
          state_d    = StCRd;
`endif
        end
      end
`ifdef TOKEN_DECODER_INDEX_EN
      StBuild: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (bus.vocab_rdata == TermChar) begin
            if (at_start_q) state_d = StCRd;
            at_start_d = 1'b1;
          end else begin
            if (at_start_q) begin
              idx_we = 1'b1;
              cnt_d  = cnt_q + OneA;
            end
            at_start_d = 1'b0;
          end
          va_d = va_q + OneA;
          if (va_q == AddrMax) state_d = StCRd;
        end
      end
`endif
      StCRd: state_d = StCChk;
      StCChk: begin
        if (bus.code_rdata == TermChar) begin
          state_d = StTerm;
        end else begin
          at_start_d = 1'b1;
`ifdef TOKEN_DECODER_INDEX_EN
          if (32'(bus.code_rdata) > 32'(cnt_q)) begin
            state_d = StErr;
          end else begin
            va_d    = idx_rdata;
            state_d = StVRd;
          end
`else
          va_d    = '0;
          skip_d  = bus.code_rdata - OneD;
          state_d = (bus.code_rdata == OneD) ? StVRd : StSRd;
`endif
        end
      end
`ifndef TOKEN_DECODER_INDEX_EN
      StSRd: state_d = StSChk;
      StSChk: begin
        if ((bus.vocab_rdata == TermChar && at_start_q) || va_q == AddrMax) begin
          state_d = StErr;
        end else begin
          va_d = va_q + OneA;
          if (bus.vocab_rdata == TermChar) begin
            at_start_d = 1'b1;
            skip_d     = skip_q - OneD;
            state_d    = (skip_q == OneD) ? StVRd : StSRd;
          end else begin
            at_start_d = 1'b0;
            state_d    = StSRd;
          end
        end
      end
`endif
      StVRd: state_d = StVChk;
      StVChk: begin
        if (bus.vocab_rdata == TermChar) begin
          if (at_start_q || ac_q == AddrMax) begin
            state_d = StErr;
          end else begin
            ac_d    = ac_q + OneA;
            state_d = StCRd;
          end
        end else if (oa_q == AddrMax || va_q == AddrMax) begin
          // Last output slot is kept for the terminator.
          state_d = StErr;
        end else begin
          we         = 1'b1;
          oa_d       = oa_q + OneA;
          va_d       = va_q + OneA;
          at_start_d = 1'b0;
          state_d    = StVRd;
        end
      end
      StTerm: begin
        we      = 1'b1;
        state_d = StDone;
      end
      StDone, StErr: begin
        if (!bus.cs) begin
          ac_d    = '0;
          va_d    = '0;
          oa_d    = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ac_q       <= '0;
      va_q       <= '0;
      oa_q       <= '0;
      at_start_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef TOKEN_DECODER_INDEX_EN
      cnt_q      <= '0;
      phase_q    <= 1'b0;
`else
      skip_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ac_q       <= ac_d;
      va_q       <= va_d;
      oa_q       <= oa_d;
      at_start_q <= at_start_d;
      done_q     <= (state_d == StDone);
      err_q      <= (state_d == StErr);
`ifdef TOKEN_DECODER_INDEX_EN
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
`else
      skip_q     <= skip_d;
`endif
    end
  end

  assign bus.code_addr  = ac_q;
  assign bus.vocab_addr = va_q;
  assign bus.out_addr   = oa_q;
  assign bus.out_we     = we;
  assign bus.out_wdata  = (we && state_q == StVChk) ? bus.vocab_rdata : TermChar;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_token_decoder.sv
// Directed bench for token_decoder with behavioural 1-cycle-read SRAM models.
module tb_token_decoder;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

`ifdef TOKEN_DECODER_INDEX_EN
  localparam int S1Edges = 44;
  localparam int S2Edges = 22;
`else
  localparam int S1Edges = 42;
  localparam int S2Edges = 4;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  token_decoder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  token_decoder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  logic [7:0] code_mem  [16];
  logic [7:0] vocab_mem [16];
  logic [7:0] out_mem   [16];
  int         we_cnt;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clk) begin
    bus.code_rdata  <= code_mem[bus.code_addr];
    bus.vocab_rdata <= vocab_mem[bus.vocab_addr];
    if (clr) begin
      for (int i = 0; i < 16; i++) out_mem[i] <= 8'hAA;
      we_cnt <= 0;
    end else if (bus.out_we) begin
      out_mem[bus.out_addr] <= bus.out_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_out();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic set_codes(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                           input logic [7:0] c3);
    for (int i = 0; i < 16; i++) code_mem[i] = 8'h00;
    code_mem[0] = c0;
    code_mem[1] = c1;
    code_mem[2] = c2;
    code_mem[3] = c3;
  endtask

  // Raise cs at a negedge, count rising edges until done or err appears.
  task automatic run(input string tag, output int edges);
    bus.cs = 1'b1;
    edges  = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      edges++;
      #1;
      if (bus.done || bus.err) break;
    end
    check({tag, "_finished"}, 32'(bus.done | bus.err), 32'd1);
  endtask

  task automatic release_cs(input string tag);
    @(negedge clk) bus.cs = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_release"}, {30'd0, bus.done, bus.err}, 32'd0);
  endtask

  task automatic check_s1_image(input string tag);
    logic [7:0] exp1 [6];
    exp1 = '{8'h64, 8'h65, 8'h61, 8'h62, 8'h63, 8'h00};
    for (int i = 0; i < 6; i++) check($sformatf("%s_mem%0d", tag, i), 32'(out_mem[i]),
                                      32'(exp1[i]));
    check({tag, "_mem6_untouched"}, 32'(out_mem[6]), 32'hAA);
    check({tag, "_we_count"}, 32'(we_cnt), 32'd6);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    int   edges;
    logic hit;
    bus.cs = 1'b0;
    for (int i = 0; i < 16; i++) vocab_mem[i] = 8'h00;
    vocab_mem[0] = 8'h61; vocab_mem[1] = 8'h62; vocab_mem[2] = 8'h00;
    vocab_mem[3] = 8'h63; vocab_mem[4] = 8'h00;
    vocab_mem[5] = 8'h64; vocab_mem[6] = 8'h65; vocab_mem[7] = 8'h00;
    vocab_mem[8] = 8'h00;
    set_codes(8'd3, 8'd1, 8'd2, 8'd0);

    #1;
    check("reset_outputs", {bus.code_addr, bus.vocab_addr, bus.out_addr, bus.out_wdata,
                            bus.out_we, bus.done, bus.err}, 32'd0);
    #20 rst_n = 1'b1;
    clear_out();

    // Scenario 1: codes [3,1,2,0] -> "deabc\0"
    run("s1", edges);
    check("s1_edges", 32'(edges), 32'(S1Edges));
    check_s1_image("s1");
    repeat (2) @(posedge clk);
    #1;
    check("s1_done_hold", 32'(bus.done), 32'd1);
    release_cs("s1");

    // Scenario 2: empty code stream
    set_codes(8'd0, 8'd0, 8'd0, 8'd0);
    clear_out();
    run("s2", edges);
    check("s2_edges", 32'(edges), 32'(S2Edges));
    check("s2_mem0", 32'(out_mem[0]), 32'h00);
    check("s2_mem1_untouched", 32'(out_mem[1]), 32'hAA);
    check("s2_we_count", 32'(we_cnt), 32'd1);
    check("s2_done", 32'(bus.done), 32'd1);
    release_cs("s2");

    // Scenario 3: unknown code
    set_codes(8'd4, 8'd0, 8'd0, 8'd0);
    clear_out();
    run("s3", edges);
    check("s3_err", 32'(bus.err), 32'd1);
    check("s3_done", 32'(bus.done), 32'd0);
    check("s3_we_count", 32'(we_cnt), 32'd0);
    check("s3_mem0_untouched", 32'(out_mem[0]), 32'hAA);
    release_cs("s3");

    // Scenario 4: eight "de" tokens = 16 chars; the 16th would land in the reserved slot
    for (int i = 0; i < 16; i++) code_mem[i] = 8'd0;
    for (int i = 0; i < 8; i++) code_mem[i] = 8'd3;
    clear_out();
    run("s4", edges);
    check("s4_err", 32'(bus.err), 32'd1);
    check("s4_done", 32'(bus.done), 32'd0);
    check("s4_we_count", 32'(we_cnt), 32'd15);
    check("s4_mem13", 32'(out_mem[13]), 32'h65);
    check("s4_mem14", 32'(out_mem[14]), 32'h64);
    check("s4_mem15_untouched", 32'(out_mem[15]), 32'hAA);
    release_cs("s4");

    // Scenario 5: reset in the V_RD following the first character write
    set_codes(8'd3, 8'd1, 8'd2, 8'd0);
    clear_out();
    bus.cs = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.out_we) begin
        hit = 1'b1;
        break;
      end
    end
    check("s5_first_write_seen", 32'(hit), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("s5_reset_outputs", {bus.code_addr, bus.vocab_addr, bus.out_addr, bus.out_wdata,
                               bus.out_we, bus.done, bus.err}, 32'd0);
    bus.cs = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    clear_out();
    run("s5", edges);
    check("s5_edges", 32'(edges), 32'(S1Edges));
    check_s1_image("s5");
    release_cs("s5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
